// File: rtl/gps_accum_dump_pkg.sv
// gps_accum_dump_pkg: shared widths and arm indices for the integrate-and-dump
// correlator stage of one gps_multichannel tracking channel.
package gps_accum_dump_pkg;

  localparam int SMP_W_DEF = 3;   // signed wiped-off sample, -4..+3
  localparam int ACC_W_DEF = 32;  // accumulator / holding register width
  localparam int ARM_N     = 3;   // early, prompt, late

  typedef enum int {
    ARM_E = 0,
    ARM_P = 1,
    ARM_L = 2
  } arm_e;

endpackage

// File: rtl/gps_accum_dump_if.sv
// gps_accum_dump_if: sample/code inputs, software handshake and dump outputs
// of one correlator channel. master = channel front end / register block,
// slave = gps_accum_dump.
interface gps_accum_dump_if
  import gps_accum_dump_pkg::*;
#(
  parameter int SMP_W = SMP_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) ();

  logic                    sample_en;
  logic signed [SMP_W-1:0] i_smp;
  logic signed [SMP_W-1:0] q_smp;
  logic                    chip_e;
  logic                    chip_p;
  logic                    chip_l;
  logic                    epoch;
  logic [ACC_W-1:0]        acq_thresh;
  logic                    dump_ack;

  logic [ACC_W-1:0]        dip;
  logic [ACC_W-1:0]        dqp;
  logic [ACC_W-1:0]        die;
  logic [ACC_W-1:0]        dqe;
  logic [ACC_W-1:0]        dil;
  logic [ACC_W-1:0]        dql;
  logic                    dump_ready;
  logic                    overrun;
  logic                    acq_hit;

  modport master (
    output sample_en, i_smp, q_smp, chip_e, chip_p, chip_l, epoch,
           acq_thresh, dump_ack,
    input  dip, dqp, die, dqe, dil, dql, dump_ready, overrun, acq_hit
  );

  modport slave (
    input  sample_en, i_smp, q_smp, chip_e, chip_p, chip_l, epoch,
           acq_thresh, dump_ack,
    output dip, dqp, die, dqe, dil, dql, dump_ready, overrun, acq_hit
  );

endinterface

// File: rtl/gps_accum_dump_arm.sv
// gps_accum_dump_arm: one I/Q accumulator pair plus its dump holding registers.
// The chip maps 1 => +1, 0 => -1. On an epoch the running sums move to the
// holding registers and the epoch sample (if any) starts the new period.
// Build option: define ACC_SATURATE_EN to clamp the accumulators instead of
// letting them wrap in two's complement.
module gps_accum_dump_arm
  import gps_accum_dump_pkg::*;
#(
  parameter int SMP_W = SMP_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    mclk,
  input  logic                    mclr,
  input  logic                    sample_en,
  input  logic                    epoch,
  input  logic                    chip,
  input  logic signed [SMP_W-1:0] i_smp,
  input  logic signed [SMP_W-1:0] q_smp,
  output logic signed [ACC_W-1:0] i_acc,
  output logic signed [ACC_W-1:0] q_acc,
  output logic signed [ACC_W-1:0] i_dump,
  output logic signed [ACC_W-1:0] q_dump
);

  logic signed [ACC_W-1:0] i_acc_d, i_acc_q;
  logic signed [ACC_W-1:0] q_acc_d, q_acc_q;
  logic signed [ACC_W-1:0] i_dump_d, i_dump_q;
  logic signed [ACC_W-1:0] q_dump_d, q_dump_q;
  logic signed [SMP_W:0]   i_prod;
  logic signed [SMP_W:0]   q_prod;

  // One extra bit so that negating the most negative sample (-4) gives +4.
  function automatic logic signed [SMP_W:0] chip_prod(
    input logic signed [SMP_W-1:0] s,
    input logic                    c
  );
    logic signed [SMP_W:0] ext;
    ext = {s[SMP_W-1], s};
    return c ? ext : -ext;
  endfunction

`ifdef ACC_SATURATE_EN
  // Add at ACC_W+1 bits and clamp to the signed ACC_W range on overflow.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [SMP_W:0]   p
  );
    logic signed [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {{(ACC_W-SMP_W){p[SMP_W]}}, p};
    if (sum[ACC_W] != sum[ACC_W-1])
      return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return sum[ACC_W-1:0];
  endfunction
`else
  // Plain two's-complement add; overflow wraps silently.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [SMP_W:0]   p
  );
    return a + {{(ACC_W-SMP_W-1){p[SMP_W]}}, p};
  endfunction
`endif

  assign i_prod = chip_prod(i_smp, chip);
  assign q_prod = chip_prod(q_smp, chip);

  // Next state: accumulate on a qualified sample, or dump and restart on an epoch.
  always_comb begin
    i_acc_d  = i_acc_q;
    q_acc_d  = q_acc_q;
    i_dump_d = i_dump_q;
    q_dump_d = q_dump_q;
    if (epoch) begin
      i_dump_d = i_acc_q;
      q_dump_d = q_acc_q;
      i_acc_d  = sample_en ? acc_add('0, i_prod) : '0;
      q_acc_d  = sample_en ? acc_add('0, q_prod) : '0;
    end else if (sample_en) begin
      i_acc_d  = acc_add(i_acc_q, i_prod);
      q_acc_d  = acc_add(q_acc_q, q_prod);
    end
  end

  // Accumulator and holding registers; reset discards any partial period.
  always_ff @(posedge mclk or negedge mclr) begin
    if (!mclr) begin
      i_acc_q  <= '0;
      q_acc_q  <= '0;
      i_dump_q <= '0;
      q_dump_q <= '0;
    end else begin
      i_acc_q  <= i_acc_d;
      q_acc_q  <= q_acc_d;
      i_dump_q <= i_dump_d;
      q_dump_q <= q_dump_d;
    end
  end

  assign i_acc  = i_acc_q;
  assign q_acc  = q_acc_q;
  assign i_dump = i_dump_q;
  assign q_dump = q_dump_q;

endmodule

// File: rtl/gps_accum_dump.sv
// gps_accum_dump: integrate-and-dump correlator for one tracking channel.
// Three arms (E/P/L) integrate over a code epoch; this level owns the
// dump_ready / overrun handshake with software and the acquisition flag.
// Build option ACC_SATURATE_EN (see gps_accum_dump_arm) selects saturating
// accumulators; interface and latency are the same either way.
module gps_accum_dump
  import gps_accum_dump_pkg::*;
#(
  parameter int SMP_W = SMP_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic            mclk,
  input  logic            mclr,
  gps_accum_dump_if.slave bus
);

  logic [ARM_N-1:0]        chip_v;
  logic signed [ACC_W-1:0] acc_i  [ARM_N];
  logic signed [ACC_W-1:0] acc_q  [ARM_N];
  logic signed [ACC_W-1:0] dump_i [ARM_N];
  logic signed [ACC_W-1:0] dump_q [ARM_N];

  logic [ACC_W:0] p_mag_sum;
  logic           hit;

  logic dump_ready_d, dump_ready_q;
  logic overrun_d, overrun_q;
  logic acq_hit_d, acq_hit_q;

  assign chip_v = {bus.chip_l, bus.chip_p, bus.chip_e};

  for (genvar g = 0; g < ARM_N; g++) begin : g_arm
    gps_accum_dump_arm #(
      .SMP_W(SMP_W),
      .ACC_W(ACC_W)
    ) u_arm (
      .mclk     (mclk),
      .mclr     (mclr),
      .sample_en(bus.sample_en),
      .epoch    (bus.epoch),
      .chip     (chip_v[g]),
      .i_smp    (bus.i_smp),
      .q_smp    (bus.q_smp),
      .i_acc    (acc_i[g]),
      .q_acc    (acc_q[g]),
      .i_dump   (dump_i[g]),
      .q_dump   (dump_q[g])
    );
  end

  // Magnitude as unsigned ACC_W: the most negative value maps to 2^(ACC_W-1).
  function automatic logic [ACC_W-1:0] mag(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-1:0] pos;
    logic [ACC_W-1:0] neg;
    pos = v;
    neg = -v;
    return v[ACC_W-1] ? neg : pos;
  endfunction

  // Prompt power proxy on the sums about to be dumped, one bit wider so it never wraps.
  assign p_mag_sum = {1'b0, mag(acc_i[ARM_P])} + {1'b0, mag(acc_q[ARM_P])};
  assign hit       = p_mag_sum > {1'b0, bus.acq_thresh};

  // Handshake: an epoch publishes a dump; an ack alone retires it; an epoch
  // while the old dump is still unread (and not acked this cycle) is an overrun.
  always_comb begin
    dump_ready_d = dump_ready_q;
    overrun_d    = overrun_q;
    acq_hit_d    = acq_hit_q;
    if (bus.epoch) begin
      dump_ready_d = 1'b1;
      acq_hit_d    = hit;
      if (dump_ready_q && !bus.dump_ack)
        overrun_d = 1'b1;
    end else if (bus.dump_ack) begin
      dump_ready_d = 1'b0;
    end
  end

  // Control registers; overrun is sticky until reset.
  always_ff @(posedge mclk or negedge mclr) begin
    if (!mclr) begin
      dump_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      acq_hit_q    <= 1'b0;
    end else begin
      dump_ready_q <= dump_ready_d;
      overrun_q    <= overrun_d;
      acq_hit_q    <= acq_hit_d;
    end
  end

  assign bus.dip        = dump_i[ARM_P];
  assign bus.dqp        = dump_q[ARM_P];
  assign bus.die        = dump_i[ARM_E];
  assign bus.dqe        = dump_q[ARM_E];
  assign bus.dil        = dump_i[ARM_L];
  assign bus.dql        = dump_q[ARM_L];
  assign bus.dump_ready = dump_ready_q;
  assign bus.overrun    = overrun_q;
  assign bus.acq_hit    = acq_hit_q;

endmodule
